phase_sequencer: RTL and testbench



---
 rtl/phase_sequencer.sv | 112 +++++++++++
 tb/tb_phase_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Run controller for a one-hot ring counter: syncs the ring to phase 0, steps it for a
// requested number of rotations, and traps any illegal transition in a sticky error state.
module phase_sequencer #(
    parameter int N     = 4,
    parameter int ROT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ROT_W-1:0] count,
    input  logic [N-1:0]     phase,
    output logic             ring_en,
    output logic [N-1:0]     strobe,
    output logic             busy,
    output logic             done,
    output logic [ROT_W-1:0] rot_count,
    output logic             err
);

    localparam int TW = $clog2(N + 2);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SYNC = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    localparam logic [N-1:0]  PHASE0   = N'(1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(N);

    logic [2:0]       state_q, state_d;
    logic [ROT_W-1:0] target_q, target_d;
    logic [ROT_W-1:0] rot_q, rot_d;
    logic [ROT_W-1:0] rot_inc;
    logic [TW-1:0]    timer_q, timer_d;
    logic [N-1:0]     exp_q, exp_d;
    logic             first_q, first_d;
    logic             phase_onehot;
    logic             step_bad;

    assign phase_onehot = (phase != '0) && ((phase & (phase - N'(1))) == '0);
    // The first RUN cycle has no prior step to compare against.
    assign step_bad     = !first_q && ((phase != exp_q) || !phase_onehot);
    assign rot_inc      = rot_q + ROT_W'(1);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        rot_d    = rot_q;
        timer_d  = timer_q;
        exp_d    = exp_q;
        first_d  = first_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rot_d    = '0;
                    target_d = count;
                    timer_d  = '0;
                    state_d  = (count == '0) ? DONE : SYNC;
                end
            end
            SYNC: begin
                if (phase == PHASE0) begin
                    state_d = RUN;
                    first_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == TIMER_LAST) state_d = ERR;
                end
            end
            RUN: begin
                exp_d   = {phase[N-2:0], phase[N-1]};
                first_d = 1'b0;
                if (step_bad) begin
                    state_d = ERR;
                end else if (phase[N-1]) begin
                    rot_d = rot_inc;
                    if (rot_inc == target_q) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            rot_q    <= '0;
            timer_q  <= '0;
            exp_q    <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            rot_q    <= rot_d;
            timer_q  <= timer_d;
            exp_q    <= exp_d;
            first_q  <= first_d;
        end
    end

    assign ring_en   = (state_q == RUN) || ((state_q == SYNC) && (phase != PHASE0));
    assign strobe    = (state_q == RUN) ? phase : '0;
    assign busy      = (state_q == SYNC) || (state_q == RUN);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);
    assign rot_count = rot_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer driving a behavioural self-correcting ring counter,
// with an override path to inject illegal phase values.
module tb_phase_sequencer;

    localparam int N     = 4;
    localparam int ROT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [ROT_W-1:0] count;
    logic [N-1:0]     phase;
    logic             ring_en;
    logic [N-1:0]     strobe;
    logic             busy;
    logic             done;
    logic [ROT_W-1:0] rot_count;
    logic             err;

    logic [N-1:0] ring_q;
    logic         load;
    logic [N-1:0] load_val;
    logic         ovr;
    logic [N-1:0] ovr_val;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Ring counter model: rotate-left, re-inserting a 1 only when the lower bits are all zero.
    always @(posedge clk) begin
        if (load) ring_q <= load_val;
        else if (ring_en) ring_q <= {ring_q[N-2:0], ~|ring_q[N-2:0]};
    end

    assign phase = ovr ? ovr_val : ring_q;

    phase_sequencer #(.N(N), .ROT_W(ROT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .phase     (phase),
        .ring_en   (ring_en),
        .strobe    (strobe),
        .busy      (busy),
        .done      (done),
        .rot_count (rot_count),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ring_en"}, 32'(ring_en), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " err"}, 32'(err), 0);
        check({tag, " rot_count"}, 32'(rot_count), 0);
        check({tag, " strobe"}, 32'(strobe), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_ring(input logic [N-1:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
    endtask

    task automatic start_run(input logic [ROT_W-1:0] c);
        start = 1'b1;
        count = c;
        tick();
        start = 1'b0;
        count = 8'hAA;
    endtask

    initial begin
        int en_cycles;
        int run_cycles;
        int k;

        reset = 1'b1; start = 1'b0; count = '0;
        load = 1'b0; load_val = '0; ovr = 1'b0; ovr_val = '0;

        // Test 1: ring at 0001, count=1
        load_ring(4'b0001);
        do_reset();
        check_reset_outputs("rst");
        start_run(8'd1);
        check("t1 sync busy", 32'(busy), 1);
        check("t1 sync ring_en", 32'(ring_en), 0);
        for (int i = 0; i < N; i++) begin
            tick();
            check($sformatf("t1 strobe%0d", i), 32'(strobe), 32'(1 << i));
        end
        tick();
        check("t1 done", 32'(done), 1);
        check("t1 rot_count", 32'(rot_count), 1);
        check("t1 err", 32'(err), 0);
        check("t1 busy", 32'(busy), 0);
        tick();
        check("t1 done pulse end", 32'(done), 0);
        check("t1 ring home", 32'(phase), 32'b0001);
        check("t1 rot hold", 32'(rot_count), 1);

        // Test 2: ring from power-up 1111, count=2
        load_ring(4'b1111);
        start_run(8'd2);
        en_cycles = 0;
        k = 0;
        while (strobe == '0 && k < 20) begin
            if (ring_en) en_cycles++;
            tick();
            k++;
        end
        check("t2 sync en cycles", 32'(en_cycles), 4);
        run_cycles = 0;
        k = 0;
        while (!done && k < 30) begin
            if (strobe != '0) run_cycles++;
            tick();
            k++;
        end
        check("t2 run cycles", 32'(run_cycles), 8);
        check("t2 done", 32'(done), 1);
        check("t2 rot_count", 32'(rot_count), 2);
        check("t2 err", 32'(err), 0);

        // Test 3: count=0
        do_reset();
        start_run(8'd0);
        check("t3 done", 32'(done), 1);
        check("t3 ring_en", 32'(ring_en), 0);
        check("t3 busy", 32'(busy), 0);
        check("t3 rot_count", 32'(rot_count), 0);
        tick();
        check("t3 idle done", 32'(done), 0);
        check("t3 idle ring_en", 32'(ring_en), 0);

        // Test 4: illegal phase mid-RUN
        load_ring(4'b0001);
        start_run(8'd3);
        tick();
        tick();
        check("t4 run strobe", 32'(strobe), 32'b0010);
        ovr = 1'b1;
        ovr_val = 4'b0110;
        tick();
        check("t4 err", 32'(err), 1);
        check("t4 ring_en", 32'(ring_en), 0);
        check("t4 strobe", 32'(strobe), 0);
        check("t4 busy", 32'(busy), 0);
        start_run(8'd1);
        check("t4 start ignored err", 32'(err), 1);
        check("t4 start ignored busy", 32'(busy), 0);
        ovr = 1'b0;
        do_reset();
        check("t4 reset err", 32'(err), 0);
        check("t4 reset busy", 32'(busy), 0);

        // Test 5: sync timeout with phase stuck at 0000
        ovr = 1'b1;
        ovr_val = 4'b0000;
        start_run(8'd1);
        check("t5 sync ring_en", 32'(ring_en), 1);
        for (int i = 0; i < N; i++) tick();
        check("t5 still sync", 32'(busy), 1);
        check("t5 no err yet", 32'(err), 0);
        tick();
        check("t5 timeout err", 32'(err), 1);
        ovr = 1'b0;
        do_reset();

        // Test 6: reset mid-run after 3 of 5 rotations, then a fresh run
        load_ring(4'b0001);
        start_run(8'd5);
        k = 0;
        while (rot_count != 8'd3 && k < 40) begin
            tick();
            k++;
        end
        check("t6 reached 3", 32'(rot_count), 3);
        check("t6 busy mid", 32'(busy), 1);
        do_reset();
        check_reset_outputs("t6 rst");
        start_run(8'd1);
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        check("t6 done", 32'(done), 1);
        check("t6 rot_count", 32'(rot_count), 1);
        check("t6 err", 32'(err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
